// File: rtl/sar_slt_search.sv
// Signed successive-approximation search: drives probes to a set-less-than responder
// and finds the largest signed x with x < hidden, flagging the case where none exists.
module sar_slt_search #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         none,
    output logic [N-1:0] probe,
    output logic         probe_valid,
    input  logic         lt_valid,
    input  logic         lt
);

    localparam int IW = (N > 2) ? $clog2(N) : 1;
    localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};
    localparam logic [IW-1:0] TOP_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [N-1:0]  u, u_next;
    logic [N-1:0]  trial;
    logic [IW-1:0] bit_idx, bit_idx_next, lower_idx;
    logic          seen_lt, seen_lt_next;
    logic [N-1:0]  result_next;
    logic          none_next;
    logic          accept;

    // Handshake: a transaction completes on any cycle where probe_valid && lt_valid;
    // probe stays stable and lt is ignored on every other cycle.
    assign accept    = probe_valid && lt_valid;
    assign lower_idx = bit_idx - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u       <= '0;
            bit_idx <= TOP_IDX;
            seen_lt <= 1'b0;
            result  <= '0;
            none    <= 1'b0;
        end else begin
            u       <= u_next;
            bit_idx <= bit_idx_next;
            seen_lt <= seen_lt_next;
            result  <= result_next;
            none    <= none_next;
        end
    end

    always_comb begin
        state_next   = state;
        u_next       = u;
        bit_idx_next = bit_idx;
        seen_lt_next = seen_lt;
        result_next  = result;
        none_next    = none;
        trial        = u;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_PROBE;
                    u_next       = MSB;
                    bit_idx_next = TOP_IDX;
                    seen_lt_next = 1'b0;
                end
            end
            S_PROBE: begin
                if (accept) begin
                    trial[bit_idx] = lt;
                    seen_lt_next   = seen_lt | lt;
                    if (bit_idx != '0) begin
                        trial[lower_idx] = 1'b1;
                        bit_idx_next     = lower_idx;
                    end else if (seen_lt || lt || (trial != '0)) begin
                        state_next  = S_DONE;
                        result_next = trial ^ MSB;
                        none_next   = 1'b0;
                    end else begin
                        // All answers were 0: hidden is min or min+1, one more probe at min decides.
                        state_next = S_CHECK;
                    end
                    u_next = trial;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_next  = S_DONE;
                    result_next = u ^ MSB;
                    none_next   = ~lt;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        probe_valid = 1'b0;
        probe       = '0;
        case (state)
            S_PROBE, S_CHECK: begin
                busy        = 1'b1;
                probe_valid = 1'b1;
                probe       = u ^ MSB;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_slt_search.sv
// Bench for sar_slt_search: an N=8 and an N=32 instance, each driven by a model responder,
// with expected results/latencies queued by the drivers and checked by done monitors.
module tb_sar_slt_search;

    logic clk;
    logic rst_n;

    logic        start8, busy8, done8, none8, probe_valid8, lt_valid8, lt8;
    logic [7:0]  result8, probe8, hidden8;
    logic        start32, busy32, done32, none32, probe_valid32, lt_valid32, lt32;
    logic [31:0] result32, probe32, hidden32;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt8 = 0;
    int done_cnt32 = 0;
    int wait32 = 0;
    int cnt32 = 0;
    logic held32 = 1'b0;
    logic [31:0] last_probe32 = '0;

    logic [40:0] exp8_q[$];
    logic [64:0] exp32_q[$];
    logic [7:0]  exp_probe8_q[$];

    sar_slt_search #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
        .result(result8), .none(none8), .probe(probe8), .probe_valid(probe_valid8),
        .lt_valid(lt_valid8), .lt(lt8)
    );

    sar_slt_search #(.N(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .busy(busy32), .done(done32),
        .result(result32), .none(none32), .probe(probe32), .probe_valid(probe_valid32),
        .lt_valid(lt_valid32), .lt(lt32)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // zero-wait responder for the 8-bit instance, optionally checking the probe sequence
    always @(negedge clk) begin
        if (probe_valid8) begin
            lt_valid8 = 1'b1;
            lt8 = ($signed(probe8) < $signed(hidden8));
            if (exp_probe8_q.size() > 0) chk("probe8_seq", 64'(probe8), 64'(exp_probe8_q.pop_front()));
        end else begin
            lt_valid8 = 1'b0;
            lt8 = 1'b0;
        end
    end

    // responder for the 32-bit instance with wait32 idle cycles before each answer
    always @(negedge clk) begin
        if (probe_valid32 && held32) chk("probe32_hold", 64'(probe32), 64'(last_probe32));
        if (!probe_valid32) begin
            lt_valid32 = 1'b0;
            lt32 = 1'b0;
            cnt32 = 0;
        end else if (cnt32 < wait32) begin
            lt_valid32 = 1'b0;
            lt32 = $urandom_range(1, 0) == 1;
            cnt32++;
        end else begin
            lt_valid32 = 1'b1;
            lt32 = ($signed(probe32) < $signed(hidden32));
            cnt32 = 0;
        end
        held32 = probe_valid32 && !lt_valid32;
        last_probe32 = probe32;
    end

    // monitors: pop expected {done cycle, none, result} whenever done pulses
    always @(negedge clk) begin
        logic [40:0] e8;
        if (rst_n && done8) begin
            done_cnt8++;
            if (exp8_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8_unexpected: got done with result %0h, required no done", result8);
            end else begin
                e8 = exp8_q.pop_front();
                chk("result8", 64'(result8), 64'(e8[7:0]));
                chk("none8", 64'(none8), 64'(e8[8]));
                chk("done8_cycle", 64'(cyc), 64'(e8[40:9]));
            end
        end
    end

    always @(negedge clk) begin
        logic [64:0] e32;
        if (rst_n && done32) begin
            done_cnt32++;
            if (exp32_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done32_unexpected: got done with result %0h, required no done", result32);
            end else begin
                e32 = exp32_q.pop_front();
                chk("result32", 64'(result32), 64'(e32[31:0]));
                chk("none32", 64'(none32), 64'(e32[32]));
                chk("done32_cycle", 64'(cyc), 64'(e32[64:33]));
            end
        end
    end

    // drivers
    task automatic run8(input logic [7:0] h, input logic [7:0] r, input logic nn,
                        input int lat, input logic extra_start);
        int prev;
        int n;
        @(negedge clk);
        hidden8 = h;
        prev = done_cnt8;
        exp8_q.push_back({32'(cyc + lat), nn, r});
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        if (extra_start) begin
            repeat (2) @(negedge clk);
            start8 = 1'b1;
            repeat (2) @(negedge clk);
            start8 = 1'b0;
        end
        n = 0;
        while (done_cnt8 == prev && n < lat + 20) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt8 == prev) begin
            checks++;
            errors++;
            $display("FAIL done8_timeout: got no done after %0d cycles, required done", n);
            void'(exp8_q.pop_front());
        end
    endtask

    task automatic run32(input logic [31:0] h, input logic [31:0] r, input logic nn,
                         input int waits, input int lat);
        int prev;
        int n;
        @(negedge clk);
        hidden32 = h;
        wait32 = waits;
        prev = done_cnt32;
        exp32_q.push_back({32'(cyc + lat), nn, r});
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        n = 0;
        while (done_cnt32 == prev && n < lat + 40) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt32 == prev) begin
            checks++;
            errors++;
            $display("FAIL done32_timeout: got no done after %0d cycles, required done", n);
            void'(exp32_q.pop_front());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0;
        start32 = 1'b0;
        hidden8 = '0;
        hidden32 = '0;
        lt_valid8 = 1'b0;
        lt8 = 1'b0;
        lt_valid32 = 1'b0;
        lt32 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        chk("rst_pv8", 64'(probe_valid8), 64'd0);
        chk("rst_probe8", 64'(probe8), 64'd0);
        chk("rst_result8", 64'(result8), 64'd0);
        chk("rst_none8", 64'(none8), 64'd0);
        chk("rst_busy32", 64'(busy32), 64'd0);
        chk("rst_pv32", 64'(probe_valid32), 64'd0);
        chk("rst_probe32", 64'(probe32), 64'd0);
        chk("rst_result32", 64'(result32), 64'd0);
        rst_n = 1'b1;

        // hidden=5: probes 0,64,32,16,8,4,6,5 -> result 4
        exp_probe8_q = '{8'd0, 8'd64, 8'd32, 8'd16, 8'd8, 8'd4, 8'd6, 8'd5};
        run8(8'd5, 8'd4, 1'b0, 9, 1'b0);
        chk("probe8_seq_drained", 64'(exp_probe8_q.size()), 64'd0);
        run8(8'd127, 8'd126, 1'b0, 9, 1'b0);
        run8(8'h80, 8'h80, 1'b1, 10, 1'b0);
        run8(8'h81, 8'h80, 1'b0, 10, 1'b0);
        run8(8'hFF, 8'hFE, 1'b0, 9, 1'b0);
        run8(8'd0, 8'hFF, 1'b0, 9, 1'b0);
        run8(8'hCE, 8'hCD, 1'b0, 9, 1'b0);
        run8(8'd20, 8'd19, 1'b0, 9, 1'b1);

        run32(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 3, 32 * 4 + 1);
        run32(32'h1234_5678, 32'h1234_5677, 1'b0, 0, 33);
        run32(32'h8000_0000, 32'h8000_0000, 1'b1, 1, 32 * 2 + 3);

        // reset in the middle of a probe wait
        @(negedge clk);
        hidden32 = 32'hFFFF_FFFF;
        wait32 = 3;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_pv32_before", 64'(probe_valid32), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pv32", 64'(probe_valid32), 64'd0);
        chk("mid_rst_busy32", 64'(busy32), 64'd0);
        chk("mid_rst_result32", 64'(result32), 64'd0);
        chk("mid_rst_none32", 64'(none32), 64'd0);
        chk("mid_rst_probe32", 64'(probe32), 64'd0);
        chk("mid_rst_result8", 64'(result8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run32(32'd0, 32'hFFFF_FFFF, 1'b0, 3, 32 * 4 + 1);

        repeat (3) @(negedge clk);
        chk("exp8_q_empty", 64'(exp8_q.size()), 64'd0);
        chk("exp32_q_empty", 64'(exp32_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
